// File: rtl/usb_rx_pkg.sv
// Purpose: shared types and constants for the USB receive packet decoder.
// Latency: n/a (types, constants and a combinational PID decode helper only).
// Backpressure: n/a.
package usb_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PID      = 2'd1,
      ST_DATA     = 2'd2,
      ST_WAIT_EOP = 2'd3
   } rx_state_e;

   typedef enum logic [2:0] {
      PKT_NONE  = 3'd0,
      PKT_OUT   = 3'd1,
      PKT_IN    = 3'd2,
      PKT_DATA0 = 3'd3,
      PKT_DATA1 = 3'd4,
      PKT_ACK   = 3'd5,
      PKT_NAK   = 3'd6,
      PKT_STALL = 3'd7
   } rx_pkt_e;

   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_STALL = 4'b1110;

   localparam logic [7:0] SYNC_BYTE = 8'h80;

   // Returns PKT_NONE when the check nibble is not the complement of the
   // PID nibble, or when the nibble is not one this decoder understands.
   function automatic rx_pkt_e pid_decode(input logic [7:0] pid_byte);
      rx_pkt_e code;
      code = PKT_NONE;
      if (pid_byte[3:0] == ~pid_byte[7:4]) begin
         case (pid_byte[3:0])
            PID_OUT:   code = PKT_OUT;
            PID_IN:    code = PKT_IN;
            PID_DATA0: code = PKT_DATA0;
            PID_DATA1: code = PKT_DATA1;
            PID_ACK:   code = PKT_ACK;
            PID_NAK:   code = PKT_NAK;
            PID_STALL: code = PKT_STALL;
            default:   code = PKT_NONE;
         endcase
      end
      return code;
   endfunction

endpackage

// File: rtl/flex_stp_sr.sv
// Purpose: flexible serial-to-parallel shift register with synchronous clear.
// Latency: new bit visible on parallel_out one clk after the shift edge.
// Backpressure: none; shifts whenever shift_enable is high.
//
// Ports:
//   clk, n_rst          clock, async active-low reset (register clears to 0)
//   shift_enable        shift one bit in this cycle
//   clear               synchronous clear, wins over shift_enable
//   serial_in           incoming bit
//   parallel_out        current register contents
module flex_stp_sr #(
   parameter int NUM_BITS  = 8,
   parameter bit SHIFT_MSB = 1'b0
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                shift_enable,
   input  logic                clear,
   input  logic                serial_in,
   output logic [NUM_BITS-1:0] parallel_out
);

   logic [NUM_BITS-1:0] sr_q, sr_d;

   // SHIFT_MSB=0: new bit enters the MSB and the word moves toward the LSB,
   // so an LSB-first stream lands in natural bit order after NUM_BITS shifts.
   always_comb begin
      sr_d = sr_q;
      if (clear) begin
         sr_d = '0;
      end else if (shift_enable) begin
         if (SHIFT_MSB) begin
            sr_d = {sr_q[NUM_BITS-2:0], serial_in};
         end else begin
            sr_d = {serial_in, sr_q[NUM_BITS-1:1]};
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign parallel_out = sr_q;

endmodule

// File: rtl/usb_rx_packet_decoder.sv
// Purpose: USB receive packet decoder: SYNC hunt, PID check, byte assembly.
// Latency: every status/data pulse appears 1 clk after the strobe edge that causes it.
// Backpressure: none; the bit stream cannot be stalled, outputs are one-cycle pulses.
//
// Ports:
//   clk, n_rst                    clock, async active-low reset
//   shift_strobe, serial_in, eop  one bit time per strobe; eop marks an EOP bit time
//   rx_data, rx_data_valid        last assembled byte and its one-cycle pulse
//   rx_packet, rx_packet_valid    decoded packet type and clean-end pulse
//   rx_error                      one-cycle pulse when a packet is aborted
//   rx_busy                       high from SYNC match until back in IDLE
//   byte_count                    bytes assembled after the PID in this packet
module usb_rx_packet_decoder
   import usb_rx_pkg::*;
#(
   parameter int MAX_BYTES = 66
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       shift_strobe,
   input  logic       serial_in,
   input  logic       eop,
   output logic [7:0] rx_data,
   output logic       rx_data_valid,
   output logic [2:0] rx_packet,
   output logic       rx_packet_valid,
   output logic       rx_error,
   output logic       rx_busy,
   output logic [6:0] byte_count
);

   logic       shift_en;
   logic       eop_stb;
   logic       sr_clear;
   logic [7:0] sr_win;
   logic [7:0] win_nxt;
   logic       last_bit;
   logic       do_abort;
   logic       do_finish;

   rx_state_e  state_q, state_d;
   rx_pkt_e    pkt_q, pkt_d, pid_code;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] byte_cnt_q, byte_cnt_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       data_vld_q, data_vld_d;
   logic       pkt_vld_q, pkt_vld_d;
   logic       err_q, err_d;
   logic       busy_q, busy_d;

   assign shift_en = shift_strobe & ~eop;
   assign eop_stb  = shift_strobe & eop;

   flex_stp_sr #(
      .NUM_BITS  (8),
      .SHIFT_MSB (1'b0)
   ) u_sr (
      .clk          (clk),
      .n_rst        (n_rst),
      .shift_enable (shift_en),
      .clear        (sr_clear),
      .serial_in    (serial_in),
      .parallel_out (sr_win)
   );

   // Window as it will stand after this edge; lets SYNC, PID and data bytes
   // be acted on at the same edge that shifts in their last bit.
   assign win_nxt  = shift_en ? {serial_in, sr_win[7:1]} : sr_win;
   assign last_bit = (bit_cnt_q == 3'd7);

   always_comb begin
      state_d    = state_q;
      pkt_d      = pkt_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      rx_data_d  = rx_data_q;
      data_vld_d = 1'b0;
      pkt_vld_d  = 1'b0;
      err_d      = 1'b0;
      busy_d     = busy_q;
      sr_clear   = 1'b0;
      do_abort   = 1'b0;
      do_finish  = 1'b0;
      pid_code   = pid_decode(win_nxt);

      case (state_q)
         ST_IDLE: begin
            if (shift_en && (win_nxt == SYNC_BYTE)) begin
               state_d    = ST_PID;
               bit_cnt_d  = 3'd0;
               byte_cnt_d = 7'd0;
               busy_d     = 1'b1;
               pkt_d      = PKT_NONE;
            end
         end

         ST_PID: begin
            if (eop_stb) begin
               do_abort = 1'b1;
            end else if (shift_en) begin
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (last_bit) begin
                  if (pid_code == PKT_NONE) begin
                     do_abort = 1'b1;
                  end else begin
                     pkt_d = pid_code;
                     if ((pid_code == PKT_OUT) || (pid_code == PKT_IN) ||
                         (pid_code == PKT_DATA0) || (pid_code == PKT_DATA1)) begin
                        state_d = ST_DATA;
                     end else begin
                        state_d = ST_WAIT_EOP;
                     end
                  end
               end
            end
         end

         ST_DATA: begin
            if (eop_stb) begin
               // Tokens carry exactly two bytes (address/endpoint + CRC5).
               if ((bit_cnt_q != 3'd0) ||
                   (((pkt_q == PKT_OUT) || (pkt_q == PKT_IN)) && (byte_cnt_q != 7'd2))) begin
                  do_abort = 1'b1;
               end else begin
                  do_finish = 1'b1;
               end
            end else if (shift_en) begin
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (last_bit) begin
                  if (byte_cnt_q == 7'(MAX_BYTES)) begin
                     do_abort = 1'b1;
                  end else begin
                     rx_data_d  = win_nxt;
                     data_vld_d = 1'b1;
                     byte_cnt_d = byte_cnt_q + 7'd1;
                  end
               end
            end
         end

         ST_WAIT_EOP: begin
            if (eop_stb) begin
               do_finish = 1'b1;
            end else if (shift_en) begin
               do_abort = 1'b1;
            end
         end

         default: begin
            do_abort = 1'b1;
         end
      endcase

      if (do_abort) begin
         state_d    = ST_IDLE;
         err_d      = 1'b1;
         busy_d     = 1'b0;
         bit_cnt_d  = 3'd0;
         sr_clear   = 1'b1;
         data_vld_d = 1'b0;
      end
      if (do_finish) begin
         state_d   = ST_IDLE;
         pkt_vld_d = 1'b1;
         busy_d    = 1'b0;
         bit_cnt_d = 3'd0;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= ST_IDLE;
         pkt_q      <= PKT_NONE;
         bit_cnt_q  <= 3'd0;
         byte_cnt_q <= 7'd0;
         rx_data_q  <= 8'd0;
         data_vld_q <= 1'b0;
         pkt_vld_q  <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pkt_q      <= pkt_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         rx_data_q  <= rx_data_d;
         data_vld_q <= data_vld_d;
         pkt_vld_q  <= pkt_vld_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
      end
   end

   assign rx_data         = rx_data_q;
   assign rx_data_valid   = data_vld_q;
   assign rx_packet       = pkt_q;
   assign rx_packet_valid = pkt_vld_q;
   assign rx_error        = err_q;
   assign rx_busy         = busy_q;
   assign byte_count      = byte_cnt_q;

endmodule

// File: tb/tb_usb_rx_packet_decoder.sv
// Purpose: self-checking bench for usb_rx_packet_decoder (scoreboard + packet-level model).
// Latency: n/a.
// Backpressure: n/a.
module tb_usb_rx_packet_decoder;

   localparam int MAXB = 66;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       shift_strobe;
   logic       serial_in;
   logic       eop;
   logic [7:0] rx_data;
   logic       rx_data_valid;
   logic [2:0] rx_packet;
   logic       rx_packet_valid;
   logic       rx_error;
   logic       rx_busy;
   logic [6:0] byte_count;

   always #5 clk = ~clk;

   usb_rx_packet_decoder #(.MAX_BYTES(MAXB)) dut (
      .clk             (clk),
      .n_rst           (n_rst),
      .shift_strobe    (shift_strobe),
      .serial_in       (serial_in),
      .eop             (eop),
      .rx_data         (rx_data),
      .rx_data_valid   (rx_data_valid),
      .rx_packet       (rx_packet),
      .rx_packet_valid (rx_packet_valid),
      .rx_error        (rx_error),
      .rx_busy         (rx_busy),
      .byte_count      (byte_count)
   );

   // kind: 0 = data byte, 1 = clean packet end, 2 = error
   typedef struct {
      int         kind;
      logic [7:0] dat;
      logic [2:0] pkt;
      logic [6:0] cnt;
   } ev_t;

   ev_t        exp_q[$];
   logic [7:0] pl[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         cycles   = 0;
   bit         done     = 1'b0;

   // Full PID bytes as they appear on the wire, mapped to rx_packet codes.
   function automatic logic [2:0] ref_code(input logic [7:0] pid);
      logic [2:0] c;
      case (pid)
         8'hE1:   c = 3'd1;
         8'h69:   c = 3'd2;
         8'hC3:   c = 3'd3;
         8'h4B:   c = 3'd4;
         8'hD2:   c = 3'd5;
         8'h5A:   c = 3'd6;
         8'h1E:   c = 3'd7;
         default: c = 3'd0;
      endcase
      return c;
   endfunction

   task automatic push(input int kind, input logic [7:0] dat, input logic [2:0] pkt,
                       input logic [6:0] cnt);
      ev_t e;
      e.kind = kind;
      e.dat  = dat;
      e.pkt  = pkt;
      e.cnt  = cnt;
      exp_q.push_back(e);
   endtask

   task automatic strobe(input logic b, input logic e);
      int g;
      shift_strobe = 1'b1;
      serial_in    = b;
      eop          = e;
      @(posedge clk);
      #1;
      shift_strobe = 1'b0;
      serial_in    = 1'b0;
      eop          = 1'b0;
      g = $urandom_range(0, 2);
      for (int i = 0; i < g; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bits(input logic [7:0] b, input int nbits);
      for (int i = 0; i < nbits; i++) strobe(b[i], 1'b0);
   endtask

   // Sends one packet (payload taken from pl) and queues the expected events.
   task automatic packet(input logic [7:0] pid, input int pid_bits, input int extra,
                         input bit hs_bit);
      logic [2:0] code;
      int         n;
      code = ref_code(pid);
      n    = pl.size();
      send_bits(8'h80, 8);
      if (pid_bits < 8) begin
         push(2, 8'd0, 3'd0, 7'd0);
         send_bits(pid, pid_bits);
         strobe(1'($urandom_range(0, 1)), 1'b1);
         return;
      end
      if (code == 3'd0) begin
         push(2, 8'd0, 3'd0, 7'd0);
         send_bits(pid, 8);
         return;
      end
      send_bits(pid, 8);
      if (code >= 3'd5) begin
         if (hs_bit) begin
            push(2, 8'd0, 3'd0, 7'd0);
            strobe(1'($urandom_range(0, 1)), 1'b0);
         end else begin
            push(1, 8'd0, code, 7'd0);
            strobe(1'($urandom_range(0, 1)), 1'b1);
         end
         return;
      end
      for (int i = 0; i < n; i++) begin
         if (i >= MAXB) begin
            push(2, 8'd0, 3'd0, 7'd0);
            send_bits(pl[i], 8);
            return;
         end
         push(0, pl[i], code, 7'(i + 1));
         send_bits(pl[i], 8);
      end
      for (int j = 0; j < extra; j++) strobe(1'($urandom_range(0, 1)), 1'b0);
      if ((extra != 0) || (((code == 3'd1) || (code == 3'd2)) && (n != 2)))
         push(2, 8'd0, 3'd0, 7'd0);
      else
         push(1, 8'd0, code, 7'(n));
      strobe(1'($urandom_range(0, 1)), 1'b1);
   endtask

   task automatic fill_random(input int n);
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
   endtask

   task automatic idle_gap();
      int g;
      g = $urandom_range(0, 3);
      for (int i = 0; i < g; i++) begin
         if ($urandom_range(0, 1) == 1) strobe(1'($urandom_range(0, 1)), 1'b1);
         else strobe(1'b0, 1'b0);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: all comparisons happen here, on the falling edge.
   always @(negedge clk) begin : mon
      ev_t e;
      int  kind_act;
      cycles++;
      if (!n_rst) begin
         chk("reset_outputs", 32'({rx_data, rx_data_valid, rx_packet, rx_packet_valid,
                                   rx_error, rx_busy, byte_count}), 32'd0);
      end else if (rx_data_valid || rx_packet_valid || rx_error) begin
         chk("pulse_overlap", 32'(rx_data_valid) + 32'(rx_packet_valid) + 32'(rx_error), 32'd1);
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", 32'({rx_data_valid, rx_packet_valid, rx_error}), 32'd0);
         end else begin
            e = exp_q.pop_front();
            kind_act = rx_error ? 2 : (rx_packet_valid ? 1 : 0);
            chk("event_kind", 32'(kind_act), 32'(e.kind));
            if (e.kind == 0) begin
               chk("rx_data", 32'(rx_data), 32'(e.dat));
               chk("byte_count_data", 32'(byte_count), 32'(e.cnt));
               chk("rx_packet_data", 32'(rx_packet), 32'(e.pkt));
               chk("rx_busy_data", 32'(rx_busy), 32'd1);
            end else if (e.kind == 1) begin
               chk("rx_packet_end", 32'(rx_packet), 32'(e.pkt));
               chk("byte_count_end", 32'(byte_count), 32'(e.cnt));
               chk("rx_busy_end", 32'(rx_busy), 32'd0);
            end else begin
               chk("rx_busy_error", 32'(rx_busy), 32'd0);
            end
         end
      end
      if (done) begin
         chk("events_outstanding", 32'(exp_q.size()), 32'd0);
         $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
         $finish;
      end else if (cycles > 60000) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout: %0d events still pending", exp_q.size());
         $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
         $finish;
      end
   end

   initial begin : stim
      int         sel;
      logic [7:0] pid;
      n_rst        = 1'b0;
      shift_strobe = 1'b0;
      serial_in    = 1'b0;
      eop          = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_rst = 1'b1;
      @(posedge clk);
      #1;

      // ACK handshake
      pl.delete();
      packet(8'hD2, 8, 0, 1'b0);
      idle_gap();

      // DATA0 with fixed payload
      pl.delete();
      pl.push_back(8'hA5);
      pl.push_back(8'h3C);
      pl.push_back(8'h11);
      pl.push_back(8'h22);
      packet(8'hC3, 8, 0, 1'b0);
      idle_gap();

      // Bad PID, then NAK
      pl.delete();
      packet(8'hD3, 8, 0, 1'b0);
      packet(8'h5A, 8, 0, 1'b0);
      idle_gap();

      // Truncated byte on an OUT token
      pl.delete();
      pl.push_back(8'h05);
      packet(8'hE1, 8, 3, 1'b0);
      idle_gap();

      // Overflow: 67 bytes on DATA1
      fill_random(67);
      packet(8'h4B, 8, 0, 1'b0);
      idle_gap();

      // Async reset in the middle of DATA after two bytes, then ACK
      push(0, 8'h9C, 3'd3, 7'd1);
      push(0, 8'h47, 3'd3, 7'd2);
      send_bits(8'h80, 8);
      send_bits(8'hC3, 8);
      send_bits(8'h9C, 8);
      send_bits(8'h47, 8);
      send_bits(8'h05, 3);
      n_rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_rst = 1'b1;
      pl.delete();
      packet(8'hD2, 8, 0, 1'b0);
      idle_gap();

      // Randomized packets
      for (int k = 0; k < 40; k++) begin
         sel = $urandom_range(0, 6);
         case (sel)
            0: begin
               pid = ($urandom_range(0, 1) == 1) ? 8'hE1 : 8'h69;
               fill_random($urandom_range(0, 3));
               packet(pid, 8, 0, 1'b0);
            end
            1: begin
               pid = ($urandom_range(0, 1) == 1) ? 8'hC3 : 8'h4B;
               fill_random($urandom_range(0, 8));
               packet(pid, 8, 0, 1'b0);
            end
            2, 3: begin
               case ($urandom_range(0, 2))
                  0:       pid = 8'hD2;
                  1:       pid = 8'h5A;
                  default: pid = 8'h1E;
               endcase
               pl.delete();
               packet(pid, 8, 0, (sel == 3));
            end
            4: begin
               pid = 8'($urandom);
               fill_random($urandom_range(0, 3));
               packet(pid, 8, 0, 1'b0);
            end
            5: begin
               pid = ($urandom_range(0, 1) == 1) ? 8'hC3 : 8'hE1;
               fill_random($urandom_range(0, 3));
               packet(pid, 8, $urandom_range(1, 7), 1'b0);
            end
            default: begin
               pl.delete();
               packet(8'($urandom), $urandom_range(0, 7), 0, 1'b0);
            end
         endcase
         idle_gap();
      end

      repeat (4) @(posedge clk);
      #1;
      done = 1'b1;
   end

endmodule
